// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access unit. Turns a load/store request from the execute stage
// into one req/ack bus transaction, formats store byte lanes, and sign- or
// zero-extends load data for the Result mux. Stall holds the PC while an
// access is in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   MemRead, MemWrite           load / store request (both high = load)
//   funct3                      access size and sign (B/H/W/BU/HU)
//   ALUResult                   byte address
//   WriteData                   store data
//   ReadData                    extended load data, valid in DONE
//   Stall                       freeze PC / hold off register write
//   misaligned, bus_err         one-cycle error flags
//   m_req, m_we, m_addr,
//   m_wdata, m_be               data-memory request side
//   m_ack, m_rdata              data-memory completion side
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic        req;
  logic        aligned;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] load_ext;

  // Request decode: alignment check and store lane formatting. funct3[1:0]
  // selects the size; 1x (W and the reserved codes) is a full word.
  always_comb begin
    req       = MemRead | MemWrite;
    aligned   = 1'b1;
    be_fmt    = 4'b1111;
    wdata_fmt = WriteData;
    case (funct3[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << ALUResult[1:0];
        wdata_fmt = {4{WriteData[7:0]}};
      end
      2'b01: begin
        aligned   = ~ALUResult[0];
        be_fmt    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{WriteData[15:0]}};
      end
      default: aligned = (ALUResult[1:0] == 2'b00);
    endcase
  end

  // Load extraction uses the captured offset and size so the result does not
  // depend on whatever the execute stage presents during ACCESS.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b   = m_rdata[8*off_q +: 8];
    lane_h   = m_rdata[16*off_q[1] +: 16];
    load_ext = m_rdata;
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~f3_q[2]}}, lane_h};
      default: load_ext = m_rdata;
    endcase
  end

  // Next-state logic. A request is only accepted in IDLE; DONE always
  // returns to IDLE so the still-presented instruction is not re-issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (req && aligned) begin
          state_d = ACCESS;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          addr_d  = {ALUResult[31:2], 2'b00};
          wdata_d = wdata_fmt;
          we_d    = MemWrite & ~MemRead;
          be_d    = (MemWrite & ~MemRead) ? be_fmt : 4'b0000;
          f3_d    = funct3;
          off_d   = ALUResult[1:0];
        end
      end
      ACCESS: begin
        if (m_ack) begin
          state_d = DONE;
          rdata_d = we_q ? 32'd0 : load_ext;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs come from state and registers only. The IDLE-cycle Stall and
  // misaligned flags are combinational and masked while reset is held.
  always_comb begin
    m_req      = (state_q == ACCESS);
    m_we       = (state_q == ACCESS) & we_q;
    m_be       = ((state_q == ACCESS) && we_q) ? be_q : 4'b0000;
    m_addr     = addr_q;
    m_wdata    = wdata_q;
    ReadData   = (state_q == DONE) ? rdata_q : 32'd0;
    bus_err    = (state_q == DONE) & err_q;
    Stall      = (state_q == ACCESS) |
                 ((state_q == IDLE) & req & aligned & ~rst);
    misaligned = (state_q == IDLE) & req & ~aligned & ~rst;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit. A table of load/store vectors is
// run through the default-timeout instance with expected ReadData values
// queued at issue and compared when DONE appears. Hand-written sequences
// cover reset, timeout with a late ack (second instance, TIMEOUT_CYCLES=4)
// and reset in the middle of an access.
module tb_load_store_unit;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        misal;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRead;
  } vecT;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, m_rdata;
  logic [31:0] ReadData, m_addr, m_wdata;
  logic        Stall, misaligned, bus_err, m_req, m_we, m_ack;
  logic [3:0]  m_be;

  logic        MemRead_t, MemWrite_t, m_ack_t;
  logic [31:0] ReadData_t, m_addr_t, m_wdata_t;
  logic        Stall_t, misaligned_t, bus_err_t, m_req_t, m_we_t;
  logic [3:0]  m_be_t;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];
  vecT vecs[13];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .misaligned(misaligned),
    .bus_err(bus_err), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dutTo (
    .clk(clk), .rst(rst), .MemRead(MemRead_t), .MemWrite(MemWrite_t),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData_t), .Stall(Stall_t), .misaligned(misaligned_t),
    .bus_err(bus_err_t), .m_req(m_req_t), .m_we(m_we_t), .m_addr(m_addr_t),
    .m_wdata(m_wdata_t), .m_be(m_be_t), .m_ack(m_ack_t), .m_rdata(m_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one table vector to completion, stepping cycle by cycle.
  task automatic applyStimulus(input vecT v);
    int  stallCnt;
    bit  done;
    logic [31:0] exp;
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wdata; m_rdata = v.rdata; m_ack = 1'b0;
    if (v.misal) begin
      @(negedge clk);
      checkOutput({v.name, ".misaligned"}, 32'(misaligned), 32'd1);
      checkOutput({v.name, ".stall"}, 32'(Stall), 32'd0);
      checkOutput({v.name, ".m_req"}, 32'(m_req), 32'd0);
      checkOutput({v.name, ".ReadData"}, ReadData, 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      checkOutput({v.name, ".misaligned_drop"}, 32'(misaligned), 32'd0);
      checkOutput({v.name, ".m_req_after"}, 32'(m_req), 32'd0);
      return;
    end
    expQ.push_back(v.expRead);
    stallCnt = 0;
    @(negedge clk);
    if (Stall) stallCnt++;
    checkOutput({v.name, ".m_req_c0"}, 32'(m_req), 32'd0);
    for (int i = 0; i <= v.delay; i++) begin
      @(posedge clk); #1;
      if (i == v.delay) m_ack = 1'b1;
      @(negedge clk);
      if (Stall) stallCnt++;
      if (i == 0) begin
        checkOutput({v.name, ".m_req"}, 32'(m_req), 32'd1);
        checkOutput({v.name, ".m_we"}, 32'(m_we), 32'(v.expWe));
        checkOutput({v.name, ".m_addr"}, m_addr, v.expAddr);
        checkOutput({v.name, ".m_be"}, 32'(m_be), 32'(v.expBe));
        if (v.expWe) checkOutput({v.name, ".m_wdata"}, m_wdata, v.expWdata);
      end
    end
    @(posedge clk); #1;
    m_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (!Stall) done = 1'b1;
      else begin
        stallCnt++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checkOutput({v.name, ".done_timeout"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      checkOutput({v.name, ".ReadData"}, ReadData, exp);
      checkOutput({v.name, ".bus_err"}, 32'(bus_err), 32'd0);
      checkOutput({v.name, ".stall_cycles"}, 32'(stallCnt), 32'(v.delay + 2));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({v.name, ".ReadData_idle"}, ReadData, 32'd0);
      checkOutput({v.name, ".m_req_idle"}, 32'(m_req), 32'd0);
    end
  endtask

  initial begin
    int reqCnt;
    vecs[0]  = '{"lw_100", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 4'b0000, 32'h100, 0, 32'hDEADBEEF};
    vecs[1]  = '{"lb_103", 1, 0, 3'b000, 32'h103, 0, 32'h80112233, 4, 0, 0, 4'b0000, 32'h100, 0, 32'hFFFFFF80};
    vecs[2]  = '{"lbu_103", 1, 0, 3'b100, 32'h103, 0, 32'h80112233, 4, 0, 0, 4'b0000, 32'h100, 0, 32'h00000080};
    vecs[3]  = '{"sh_22", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 1, 0, 1, 4'b1100, 32'h20, 32'hABCDABCD, 0};
    vecs[4]  = '{"sb_11", 0, 1, 3'b000, 32'h11, 32'h000000A5, 0, 2, 0, 1, 4'b0010, 32'h10, 32'hA5A5A5A5, 0};
    vecs[5]  = '{"lh_06", 1, 0, 3'b001, 32'h6, 0, 32'h80017FFF, 1, 0, 0, 4'b0000, 32'h4, 0, 32'hFFFF8001};
    vecs[6]  = '{"sw_40", 0, 1, 3'b010, 32'h40, 32'h12345678, 0, 0, 0, 1, 4'b1111, 32'h40, 32'h12345678, 0};
    vecs[7]  = '{"lb_101", 1, 0, 3'b000, 32'h101, 0, 32'h00007F00, 3, 0, 0, 4'b0000, 32'h100, 0, 32'h0000007F};
    vecs[8]  = '{"rdwr_both", 1, 1, 3'b010, 32'h8, 32'h55555555, 32'hCAFEF00D, 0, 0, 0, 4'b0000, 32'h8, 0, 32'hCAFEF00D};
    vecs[9]  = '{"rsv_011", 1, 0, 3'b011, 32'hC, 0, 32'h11223344, 1, 0, 0, 4'b0000, 32'hC, 0, 32'h11223344};
    vecs[10] = '{"sw_41_mis", 0, 1, 3'b010, 32'h41, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{"lh_43_mis", 1, 0, 3'b001, 32'h43, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{"rsv_111_mis", 1, 0, 3'b111, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    rst = 1'b1; MemRead = 0; MemWrite = 0; funct3 = 0; ALUResult = 0;
    WriteData = 0; m_rdata = 0; m_ack = 0;
    MemRead_t = 0; MemWrite_t = 0; m_ack_t = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.ReadData", ReadData, 32'd0);
    checkOutput("reset.Stall", 32'(Stall), 32'd0);
    checkOutput("reset.misaligned", 32'(misaligned), 32'd0);
    checkOutput("reset.bus_err", 32'(bus_err), 32'd0);
    checkOutput("reset.m_req", 32'(m_req), 32'd0);
    checkOutput("reset.m_we", 32'(m_we), 32'd0);
    checkOutput("reset.m_be", 32'(m_be), 32'd0);
    checkOutput("reset.m_addr", m_addr, 32'd0);
    checkOutput("reset.m_wdata", m_wdata, 32'd0);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // Timeout: four request cycles, then DONE with bus_err; a late ack is ignored.
    @(posedge clk); #1;
    MemRead_t = 1'b1; funct3 = 3'b010; ALUResult = 32'h200; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checkOutput("timeout.stall_c0", 32'(Stall_t), 32'd1);
    reqCnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!m_req_t) break;
      reqCnt++;
    end
    checkOutput("timeout.req_cycles", 32'(reqCnt), 32'd4);
    checkOutput("timeout.bus_err", 32'(bus_err_t), 32'd1);
    checkOutput("timeout.ReadData", ReadData_t, 32'd0);
    checkOutput("timeout.stall_done", 32'(Stall_t), 32'd0);
    @(posedge clk); #1;
    MemRead_t = 1'b0;
    @(negedge clk);
    checkOutput("timeout.bus_err_drop", 32'(bus_err_t), 32'd0);
    @(posedge clk); #1;
    m_ack_t = 1'b1;
    @(negedge clk);
    checkOutput("late_ack.m_req", 32'(m_req_t), 32'd0);
    checkOutput("late_ack.stall", 32'(Stall_t), 32'd0);
    @(posedge clk); #1;
    m_ack_t = 1'b0;
    @(negedge clk);
    checkOutput("late_ack.m_req_after", 32'(m_req_t), 32'd0);
    checkOutput("late_ack.ReadData", ReadData_t, 32'd0);
    checkOutput("late_ack.bus_err", 32'(bus_err_t), 32'd0);

    // Reset in the second ACCESS cycle abandons the access.
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h300; m_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreset.m_req_before", 32'(m_req), 32'd1);
    rst = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset.m_req", 32'(m_req), 32'd0);
    checkOutput("midreset.stall", 32'(Stall), 32'd0);
    checkOutput("midreset.m_addr", m_addr, 32'd0);
    applyStimulus('{"lhu_02", 1, 0, 3'b101, 32'h2, 0, 32'hF00D0000, 1, 0, 0, 4'b0000, 32'h0, 0, 32'h0000F00D});

    checkOutput("scoreboard.empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
